// File: rtl/banked_regfile_spill.sv
// Banked integer register file: trap entry pushes a fresh bank, trap return pops it.
// Macro BANKED_RF_SPILL_EN adds the stack-frame seed and caller-save spill to memory.
module banked_regfile_spill #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NR_READ_PORTS  = 2,
   parameter int unsigned NR_WRITE_PORTS = 1,
   parameter int unsigned NR_BANKS       = 2,
   parameter logic [31:0] SAVE_MASK      = 32'hF003FCE2
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NR_READ_PORTS-1:0][4:0]             raddr_i,
   output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
   input  logic [NR_WRITE_PORTS-1:0][4:0]            waddr_i,
   input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
   input  logic [NR_WRITE_PORTS-1:0]                 we_i,
   input  logic                                      ex_valid_i,
   input  logic                                      ret_i,
   output logic                                      busy_o,
   output logic [$clog2(NR_BANKS)-1:0]               depth_o,
   output logic                                      overflow_o,
   output logic                                      mem_req_o,
   output logic [DATA_WIDTH-1:0]                     mem_addr_o,
   output logic [DATA_WIDTH-1:0]                     mem_wdata_o,
   input  logic                                      mem_gnt_i
);
   localparam int unsigned DW       = $clog2(NR_BANKS);
   localparam logic [31:0] EFF_MASK = SAVE_MASK & ~32'h0000_0005;

   function automatic int unsigned popcount(input logic [31:0] m);
      int unsigned c;
      c = 0;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) c = c + 1;
      end
      return c;
   endfunction

   // Lowest saved register index strictly above 'from'
   function automatic logic [4:0] next_saved(input int from);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (EFF_MASK[i] && (i > from)) r = 5'(i);
      end
      return r;
   endfunction

   localparam int unsigned NR_SAVED  = popcount(EFF_MASK);
   localparam int unsigned BYTES     = DATA_WIDTH / 8;
   localparam logic [4:0]  LAST_K    = 5'((NR_SAVED == 0) ? 0 : NR_SAVED - 1);
   localparam logic [4:0]  FIRST_IDX = next_saved(-1);
`ifdef BANKED_RF_SPILL_EN
   localparam logic [DATA_WIDTH-1:0] FRAME = DATA_WIDTH'(NR_SAVED * BYTES);
`else
   localparam logic [DATA_WIDTH-1:0] FRAME = '0;
`endif
   localparam logic [DW-1:0] DEPTH_MAX = DW'(NR_BANKS - 1);
   localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, SAVE_SP = 2'd1, SPILL = 2'd2} state_e;

   state_e                state_r, state_s;
   logic [DATA_WIDTH-1:0] rf_r [NR_BANKS][32];
   logic [DW-1:0]         depth_r, wbank_s, prev_bank_s;
   logic                  busy_r, ovf_r, req_r;
   logic                  push_s, refuse_s, pop_s;
   logic [4:0]            k_r, idx_r, next_idx_s;
   logic [DATA_WIDTH-1:0] addr_r, wdata_r, sp_seed_s;

   // Trap event decode; only honoured while idle, push has priority over return
   always_comb begin
      push_s   = (state_r == IDLE) && ex_valid_i && (depth_r != DEPTH_MAX);
      refuse_s = (state_r == IDLE) && ex_valid_i && (depth_r == DEPTH_MAX);
      pop_s    = (state_r == IDLE) && !ex_valid_i && ret_i && (depth_r != '0);
   end

   // Write-bank steering and spill data sources
   always_comb begin
      prev_bank_s = depth_r - DEPTH_ONE;
      next_idx_s  = next_saved(int'(idx_r));
      sp_seed_s   = rf_r[depth_r][5'd2] - FRAME;
      if (state_r == SAVE_SP) begin
         wbank_s = depth_r + DEPTH_ONE;
      end else begin
         wbank_s = depth_r;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (push_s) state_s = SAVE_SP;
            else        state_s = IDLE;
         end
         SAVE_SP: begin
`ifdef BANKED_RF_SPILL_EN
            if (NR_SAVED != 0) state_s = SPILL;
            else               state_s = IDLE;
`else
            state_s = IDLE;
`endif
         end
         SPILL: begin
            if (mem_gnt_i && (k_r == LAST_K)) state_s = IDLE;
            else                              state_s = SPILL;
         end
         default: state_s = IDLE;
      endcase
   end

   // Control state, bank pointer, sticky overflow and the spill request registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         depth_r <= '0;
         busy_r  <= 1'b0;
         ovf_r   <= 1'b0;
         k_r     <= 5'd0;
         idx_r   <= 5'd0;
         req_r   <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         if (refuse_s) ovf_r <= 1'b1;
         if (state_r == SAVE_SP) depth_r <= depth_r + DEPTH_ONE;
         else if (pop_s)         depth_r <= depth_r - DEPTH_ONE;
         if ((state_r == SAVE_SP) && (state_s == SPILL)) begin
            k_r     <= 5'd0;
            idx_r   <= FIRST_IDX;
            req_r   <= 1'b1;
            addr_r  <= sp_seed_s;
            wdata_r <= rf_r[depth_r][FIRST_IDX];
         end else if ((state_r == SPILL) && mem_gnt_i) begin
            if (state_s == IDLE) begin
               req_r <= 1'b0;
            end else begin
               k_r     <= k_r + 5'd1;
               idx_r   <= next_idx_s;
               addr_r  <= addr_r + DATA_WIDTH'(BYTES);
               wdata_r <= rf_r[prev_bank_s][next_idx_s];
            end
         end
      end
   end

   // Bank storage; the stack-pointer seed lands after core writes so it wins on x2
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NR_BANKS; b++) begin
            for (int r = 0; r < 32; r++) rf_r[b][r] <= '0;
         end
      end else begin
         for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            if (we_i[p] && (waddr_i[p] != 5'd0)) rf_r[wbank_s][waddr_i[p]] <= wdata_i[p];
         end
         if (state_r == SAVE_SP) rf_r[wbank_s][5'd2] <= sp_seed_s;
      end
   end

   // Combinational reads from the active bank
   always_comb begin
      for (int p = 0; p < NR_READ_PORTS; p++) begin
         if (raddr_i[p] == 5'd0) rdata_o[p] = '0;
         else                    rdata_o[p] = rf_r[depth_r][raddr_i[p]];
      end
   end

   assign depth_o     = depth_r;
   assign busy_o      = busy_r;
   assign overflow_o  = ovf_r;
   assign mem_req_o   = req_r;
   assign mem_addr_o  = addr_r;
   assign mem_wdata_o = wdata_r;

endmodule
